// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the sequential shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Width of the step counter that holds WIDTH/STEP down to zero.
    function automatic int cnt_width(input int width, input int step);
        return $clog2(width / step + 1);
    endfunction

    function automatic bit step_legal(input int width, input int step);
        return ((step == 1) || (step == 2) || (step == 4)) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add sub-step: conditionally add mcand into the upper half, then shift right by one.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum_s;

    // Carry out of the add lands in the top bit, so nothing is lost on the shift.
    always_comb begin
        if (acc_i[0]) begin
            sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
        end else begin
            sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
        end
    end

    assign acc_o = {sum_s, acc_i[WIDTH-1:1]};

endmodule

// File: rtl/mul32_seq.sv
// Iterative WIDTH x WIDTH unsigned multiplier retiring STEP bits per clock with valid/ready on both sides.
// Optional two's-complement operands when MUL32_SEQ_SIGNED_EN is defined (adds port is_signed).
module mul32_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MUL32_SEQ_SIGNED_EN
    input  logic               is_signed,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CW = cnt_width(WIDTH, STEP);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / STEP);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!step_legal(WIDTH, STEP)) begin : g_bad_step
        $error("mul32_seq: STEP must be 1, 2 or 4 and divide WIDTH");
    end

    mul_state_t         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [WIDTH-1:0]   xa_s, ya_s;
    logic [2*WIDTH-1:0] chain_s [0:STEP];
    logic [2*WIDTH-1:0] res_s;

    assign chain_s[0] = acc_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        mul_step #(.WIDTH(WIDTH)) u_step (
            .acc_i  (chain_s[g]),
            .mcand_i(mcand_q),
            .acc_o  (chain_s[g+1])
        );
    end

`ifdef MUL32_SEQ_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitudes go to the unsigned core; the sign is applied when DONE is loaded.
    always_comb begin
        xa_s  = (is_signed && x[WIDTH-1]) ? ({WIDTH{1'b0}} - x) : x;
        ya_s  = (is_signed && y[WIDTH-1]) ? ({WIDTH{1'b0}} - y) : y;
        res_s = neg_q ? ({(2*WIDTH){1'b0}} - chain_s[STEP]) : chain_s[STEP];
    end
`else
    assign xa_s  = x;
    assign ya_s  = y;
    assign res_s = chain_s[STEP];
`endif

    // Next-state and datapath control for IDLE/RUN/DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        count_d = count_q;
        p_d     = p_q;
`ifdef MUL32_SEQ_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = xa_s;
                    acc_d   = {{WIDTH{1'b0}}, ya_s};
                    count_d = CNT_INIT;
                    state_d = RUN;
`ifdef MUL32_SEQ_SIGNED_EN
                    neg_d   = is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = chain_s[STEP];
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = DONE;
                    p_d     = res_s;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; handshake outputs follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {(2*WIDTH){1'b0}};
            mcand_q     <= {WIDTH{1'b0}};
            count_q     <= {CW{1'b0}};
            p_q         <= {(2*WIDTH){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUL32_SEQ_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            count_q     <= count_d;
            p_q         <= p_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
`ifdef MUL32_SEQ_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed, table-driven bench for mul32_seq (STEP=1 and STEP=4 instances).
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sgn = 1'b0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic [31:0] x = 32'h0, y = 32'h0;
    logic        out_ready = 1'b1;
    logic        in_ready, in_ready4, out_valid, out_valid4, busy, busy4;
    logic [63:0] p, p4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul32_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst(rst),
`ifdef MUL32_SEQ_SIGNED_EN
        .is_signed(sgn),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    mul32_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst),
`ifdef MUL32_SEQ_SIGNED_EN
        .is_signed(sgn),
`endif
        .in_valid(in_valid4), .in_ready(in_ready4), .x(x), .y(y),
        .out_valid(out_valid4), .out_ready(out_ready), .p(p4), .busy(busy4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] ep;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? in_ready : in_ready4;
    endfunction

    function automatic logic ov(input int w);
        return (w == 0) ? out_valid : out_valid4;
    endfunction

    function automatic logic [63:0] pp(input int w);
        return (w == 0) ? p : p4;
    endfunction

    // Issue one operation and check latency, product, and in_ready behaviour.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] ep, input int elat, input string nm);
        int lat;
        int rdy_hi;
        @(negedge clk);
        chk({nm, "_in_ready_idle"}, 64'(rdy(w)), 64'd1);
        x = a;
        y = b;
        if (w == 0) in_valid = 1'b1; else in_valid4 = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        lat = 0;
        rdy_hi = 0;
        while (!ov(w) && lat < 200) begin
            if (rdy(w)) rdy_hi++;
            @(negedge clk);
            lat++;
        end
        if (rdy(w)) rdy_hi++;
        chk({nm, "_latency"}, 64'(lat), 64'(elat));
        chk({nm, "_p"}, pp(w), ep);
        chk({nm, "_in_ready_low"}, 64'(rdy_hi), 64'd0);
        @(negedge clk);
        chk({nm, "_ov_drop"}, 64'(ov(w)), 64'd0);
        chk({nm, "_in_ready_back"}, 64'(rdy(w)), 64'd1);
    endtask

    initial begin
        int bad;
        int lat;
        logic [63:0] held;

        vecs[0] = '{32'd3,          32'd5,          64'd15};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'd0};
        vecs[3] = '{32'h8000_0000,  32'd2,          64'h1_0000_0000};
        vecs[4] = '{32'd7,          32'd6,          64'd42};
        vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h1_FFFF_FFFE};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  64'h1_0000_0000};
        vecs[7] = '{32'd5,          32'd0,          64'd0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_p", p, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(0, vecs[i].a, vecs[i].b, vecs[i].ep, 32, $sformatf("s1_v%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            do_op(1, vecs[i].a, vecs[i].b, vecs[i].ep, 8, $sformatf("s4_v%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles while offering a new operand.
        out_ready = 1'b0;
        @(negedge clk);
        x = 32'd11;
        y = 32'd13;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd32);
        held = p;
        chk("bp_p", held, 64'd143);
        x = 32'd2;
        y = 32'd2;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || p !== held || in_ready || !busy) bad++;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ov_drop", 64'(out_valid), 64'd0);
        chk("bp_in_ready", 64'(in_ready), 64'd1);
        chk("bp_p_kept", p, 64'd143);
        chk("bp_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN discards the operation.
        @(negedge clk);
        x = 32'd100;
        y = 32'd200;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_p", p, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        chk("arst_no_result", 64'(bad), 64'd0);
        do_op(0, 32'd7, 32'd6, 64'd42, 32, "arst_next");

`ifdef MUL32_SEQ_SIGNED_EN
        sgn = 1'b1;
        do_op(0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 32, "sg_neg3x5");
        do_op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32, "sg_min_min");
        do_op(1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 64'd21, 8, "sg4_neg3xneg7");
        sgn = 1'b0;
        do_op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32, "us_min_min");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
